// File: rtl/tx_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tx_sample_feeder
// Brief    : Host-to-TX sample FIFO with prefill threshold and underrun handling,
//            drained one sample per interpolator strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tx_sample_feeder #(
  parameter logic [7:0] BASE      = 8'd0,
  parameter int         FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic [31:0]          sample,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 strobe,
  input  logic                 run_in,
  output logic [23:0]          tx_i,
  output logic [23:0]          tx_q,
  output logic                 run,
  output logic                 underrun,
  output logic [15:0]          underrun_count,
  output logic [FIFO_LOG2:0]   fifo_level
);

  localparam int             c_DEPTH    = 1 << FIFO_LOG2;
  localparam int             c_PTR_W    = FIFO_LOG2;
  localparam int             c_LVL_W    = FIFO_LOG2 + 1;
  localparam logic [7:0]     c_ADDR_CFG = BASE;
  localparam logic [7:0]     c_ADDR_THR = BASE + 8'd1;
  localparam logic [7:0]     c_ADDR_CLR = BASE + 8'd2;
  localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(c_DEPTH);
  localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFILL  = 2'd1,
    ST_RUN      = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          mem_q [c_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]   level_q, level_d;
  logic [23:0]          tx_i_q, tx_i_d;
  logic [23:0]          tx_q_q, tx_q_d;
  logic                 underrun_q, underrun_d;
  logic [15:0]          count_q, count_d;
  logic                 swap_q, swap_d;
  logic                 hold_q, hold_d;
  logic [c_LVL_W-1:0]   thr_q, thr_d;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic                 w_strobe_run;
  logic                 w_pop;
  logic                 w_urun;
  logic [31:0]          w_rd_data;
  logic                 w_cfg_wr;
  logic                 w_thr_wr;
  logic                 w_clr_wr;

  assign w_full       = (level_q == c_FULL);
  assign w_empty      = (level_q == '0);
  assign sample_ready = !w_full && (state_q != ST_IDLE);
  assign w_wr         = sample_valid && sample_ready;
  assign w_rd_data    = mem_q[rd_ptr_q];

  // A write landing on an empty FIFO in the strobe cycle rescues it: no pop, no underrun.
  assign w_strobe_run = (state_q == ST_RUN) && run_in && strobe;
  assign w_pop        = w_strobe_run && !w_empty;
  assign w_urun       = w_strobe_run && w_empty && !w_wr;

  assign w_cfg_wr = set_stb && (set_addr == c_ADDR_CFG);
  assign w_thr_wr = set_stb && (set_addr == c_ADDR_THR);
  assign w_clr_wr = set_stb && (set_addr == c_ADDR_CLR);

  always_comb begin
    state_d = state_q;
    if (!run_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_PREFILL;
        ST_PREFILL,
        ST_UNDERRUN: if (level_q >= thr_q) state_d = ST_RUN;
        ST_RUN:      if (w_urun) state_d = ST_UNDERRUN;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (!run_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_wr)  wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      if (w_pop) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   level_d = level_q + c_LVL_ONE;
        2'b01:   level_d = level_q - c_LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    tx_i_d = tx_i_q;
    tx_q_d = tx_q_q;
    if (!run_in || (state_q == ST_IDLE) || (state_q == ST_PREFILL)) begin
      tx_i_d = '0;
      tx_q_d = '0;
    end else if (w_pop) begin
      if (swap_q) begin
        tx_i_d = {w_rd_data[15:0], 8'h00};
        tx_q_d = {w_rd_data[31:16], 8'h00};
      end else begin
        tx_i_d = {w_rd_data[31:16], 8'h00};
        tx_q_d = {w_rd_data[15:0], 8'h00};
      end
    end else if (w_urun && !hold_q) begin
      tx_i_d = '0;
      tx_q_d = '0;
    end
  end

  always_comb begin
    underrun_d = w_urun;
    count_d    = count_q;
    if (w_clr_wr) begin
      count_d = '0;
    end else if (w_urun && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_comb begin
    swap_d = swap_q;
    hold_d = hold_q;
    thr_d  = thr_q;
    if (w_cfg_wr) begin
      swap_d = set_data[0];
      hold_d = set_data[1];
    end
    if (w_thr_wr) begin
      thr_d = (set_data[FIFO_LOG2:0] == '0) ? c_LVL_ONE : set_data[FIFO_LOG2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_i_q     <= '0;
      tx_q_q     <= '0;
      underrun_q <= 1'b0;
      count_q    <= '0;
      swap_q     <= 1'b0;
      hold_q     <= 1'b0;
      thr_q      <= c_LVL_ONE;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_i_q     <= tx_i_d;
      tx_q_q     <= tx_q_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      swap_q     <= swap_d;
      hold_q     <= hold_d;
      thr_q      <= thr_d;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  assign tx_i           = tx_i_q;
  assign tx_q           = tx_q_q;
  assign run            = (state_q == ST_RUN);
  assign underrun       = underrun_q;
  assign underrun_count = count_q;
  assign fifo_level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_sample_feeder
// Brief    : Scoreboard bench for tx_sample_feeder against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_sample_feeder;

  localparam logic [7:0] c_BASE = 8'h40;

  logic        clk;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        strobe;
  logic        run_in;
  logic [23:0] tx_i;
  logic [23:0] tx_q;
  logic        run;
  logic        underrun;
  logic [15:0] underrun_count;
  logic [4:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  tx_sample_feeder #(.BASE(c_BASE), .FIFO_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .strobe(strobe), .run_in(run_in),
    .tx_i(tx_i), .tx_q(tx_q), .run(run), .underrun(underrun),
    .underrun_count(underrun_count), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_PREFILL, M_RUN, M_UNDERRUN} mode_t;
  typedef struct {
    logic [23:0] ti;
    logic [23:0] tq;
    logic        run;
    logic        ur;
    logic [15:0] cnt;
    logic [4:0]  lvl;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  mode_t       m_mode;
  logic [23:0] m_ti, m_tq;
  logic        m_ur, m_swap, m_hold;
  logic [15:0] m_cnt;
  int          m_thr;

  always @(posedge clk) begin
    exp_t        e;
    bit          rdy, wr;
    logic [31:0] s;
    if (rst) begin
      m_mode = M_IDLE; mq.delete();
      m_ti = '0; m_tq = '0; m_ur = 1'b0; m_cnt = '0;
      m_swap = 1'b0; m_hold = 1'b0; m_thr = 1;
    end else begin
      rdy  = (m_mode != M_IDLE) && (mq.size() < 16);
      wr   = sample_valid && rdy;
      m_ur = 1'b0;
      if (!run_in) begin
        m_mode = M_IDLE; mq.delete(); m_ti = '0; m_tq = '0;
      end else begin
        case (m_mode)
          M_IDLE: m_mode = M_PREFILL;
          M_PREFILL, M_UNDERRUN: if (mq.size() >= m_thr) m_mode = M_RUN;
          M_RUN: if (strobe) begin
            if (mq.size() > 0) begin
              s = mq.pop_front();
              m_ti = m_swap ? {s[15:0], 8'h00} : {s[31:16], 8'h00};
              m_tq = m_swap ? {s[31:16], 8'h00} : {s[15:0], 8'h00};
            end else if (!wr) begin
              m_mode = M_UNDERRUN; m_ur = 1'b1;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
              if (!m_hold) begin m_ti = '0; m_tq = '0; end
            end
          end
          default: m_mode = M_IDLE;
        endcase
        if (wr) mq.push_back(sample);
      end
      if (set_stb && set_addr == c_BASE + 8'd2) m_cnt = '0;
      if (set_stb && set_addr == c_BASE) begin m_swap = set_data[0]; m_hold = set_data[1]; end
      if (set_stb && set_addr == c_BASE + 8'd1) m_thr = (set_data[4:0] == 5'd0) ? 1 : int'(set_data[4:0]);
    end
    e.ti = m_ti; e.tq = m_tq; e.run = (m_mode == M_RUN); e.ur = m_ur; e.cnt = m_cnt;
    e.lvl = 5'(mq.size());
    e.rdy = (m_mode != M_IDLE) && (mq.size() < 16);
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_tx_i", 32'(tx_i), 32'(e.ti));
      chk("sb_tx_q", 32'(tx_q), 32'(e.tq));
      chk("sb_run", 32'(run), 32'(e.run));
      chk("sb_underrun", 32'(underrun), 32'(e.ur));
      chk("sb_count", 32'(underrun_count), 32'(e.cnt));
      chk("sb_level", 32'(fifo_level), 32'(e.lvl));
      chk("sb_ready", 32'(sample_ready), 32'(e.rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_set(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic push(input logic [31:0] s);
    int n = 0;
    sample = s; sample_valid = 1'b1;
    while (!sample_ready && n < 200) begin tick(); n++; end
    chk("push_ready", 32'(sample_ready), 32'd1);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    sample = '0; sample_valid = 1'b0; strobe = 1'b0; run_in = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_count", 32'(underrun_count), 32'd0);
    chk("rst_tx_i", 32'(tx_i), 32'd0);
    rst = 1'b0;

    // threshold 4, four pushes, then first strobe
    wr_set(c_BASE + 8'd1, 32'd4);
    run_in = 1'b1;
    tick();
    repeat (4) push(32'h03E8_FC18);
    chk("prefill_level", 32'(fifo_level), 32'd4);
    chk("prefill_run", 32'(run), 32'd0);
    tick();
    chk("run_rise", 32'(run), 32'd1);
    pulse_strobe();
    chk("first_tx_i", 32'(tx_i), 32'h0003_E800);
    chk("first_tx_q", 32'(tx_q), 32'h00FC_1800);
    repeat (3) pulse_strobe();

    // underrun with hold_last=0
    push(32'h0001_0002);
    pulse_strobe();
    pulse_strobe();
    chk("ur_pulse", 32'(underrun), 32'd1);
    chk("ur_count", 32'(underrun_count), 32'd1);
    chk("ur_tx_i", 32'(tx_i), 32'd0);
    chk("ur_run", 32'(run), 32'd0);
    for (int k = 0; k < 4; k++) push($urandom);
    tick();
    chk("ur_recover", 32'(run), 32'd1);

    // underrun with hold_last=1
    wr_set(c_BASE, 32'd2);
    repeat (4) pulse_strobe();
    push(32'h7FFF_8000);
    pulse_strobe();
    pulse_strobe();
    chk("hold_tx_i", 32'(tx_i), 32'h007F_FF00);
    chk("hold_tx_q", 32'(tx_q), 32'h0080_0000);
    chk("hold_pulse", 32'(underrun), 32'd1);

    // write on empty FIFO concurrent with strobe
    for (int k = 0; k < 4; k++) push($urandom);
    tick();
    repeat (4) pulse_strobe();
    sample = 32'h1234_5678; sample_valid = 1'b1; strobe = 1'b1;
    tick();
    sample_valid = 1'b0; strobe = 1'b0;
    chk("rescue_nour", 32'(underrun), 32'd0);
    chk("rescue_level", 32'(fifo_level), 32'd1);

    // fill to full, then one strobe frees exactly one slot
    wr_set(c_BASE, 32'd0);
    sample = 32'hAAAA_5555; sample_valid = 1'b1;
    repeat (25) tick();
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ready", 32'(sample_ready), 32'd0);
    pulse_strobe();
    repeat (4) tick();
    chk("refill_level", 32'(fifo_level), 32'd16);
    sample_valid = 1'b0;

    // swap_iq
    run_in = 1'b0;
    tick();
    chk("flush_level", 32'(fifo_level), 32'd0);
    wr_set(c_BASE, 32'd1);
    wr_set(c_BASE + 8'd1, 32'd0);
    run_in = 1'b1;
    tick();
    push(32'h0005_0007);
    tick();
    pulse_strobe();
    chk("swap_tx_i", 32'(tx_i), 32'h0000_0700);
    chk("swap_tx_q", 32'(tx_q), 32'h0000_0500);

    // run_in drop with 9 queued; clear concurrent with underrun
    wr_set(c_BASE, 32'd0);
    for (int k = 0; k < 9; k++) push($urandom);
    run_in = 1'b0;
    tick();
    chk("drop_level", 32'(fifo_level), 32'd0);
    chk("drop_tx_i", 32'(tx_i), 32'd0);
    chk("drop_tx_q", 32'(tx_q), 32'd0);
    run_in = 1'b1;
    tick();
    push(32'h0102_0304);
    tick();
    pulse_strobe();
    set_stb = 1'b1; set_addr = c_BASE + 8'd2; strobe = 1'b1;
    tick();
    set_stb = 1'b0; strobe = 1'b0;
    chk("clr_pulse", 32'(underrun), 32'd1);
    chk("clr_count", 32'(underrun_count), 32'd0);

    // reset mid-transfer
    for (int k = 0; k < 3; k++) push($urandom);
    rst = 1'b1; strobe = 1'b1;
    tick();
    rst = 1'b0; strobe = 1'b0;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ur", 32'(underrun), 32'd0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      run_in       = ($urandom_range(0, 299) != 0);
      rst          = ($urandom_range(0, 999) == 0);
      strobe       = ((i / 400) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      sample_valid = ($urandom_range(0, 1) == 1);
      sample       = $urandom;
      set_stb      = ($urandom_range(0, 29) == 0);
      set_addr     = c_BASE + 8'($urandom_range(0, 3));
      set_data     = $urandom_range(0, 6);
      tick();
    end
    rst = 1'b0; strobe = 1'b0; sample_valid = 1'b0; set_stb = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
